iterative_shifter: RTL and testbench

Parametrised multi-cycle shift unit for the datapath's ALU/branch-offset path. It generalises the fixed combinational shift-left-by-2 into a shifter with these properties:
- configurable data width;
- per-operation shift amount;
- four shift modes;
- a start/busy/done handshake.

It shifts at most STEP bit positions per clock, so a narrow shifter stage meets timing at any WIDTH.

---
 rtl/iterative_shifter.sv | 187 ++++++++++++++++++
 tb/tb_iterative_shifter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
// -----------------------------------------------------------------------------
// iterative_shifter
//
// Multi-cycle shift unit. An accepted operation is shifted by at most STEP bit
// positions per clock until the requested amount is consumed. The result is
// then published on ValueOut together with a one-cycle Done pulse.
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 8)
//   STEP   maximum bit positions shifted per clock (power of two, 1..WIDTH)
//
// Ports:
//   Clk       in   clock, rising edge
//   Reset_n   in   asynchronous active-low reset
//   Start     in   request, sampled only while Busy=0
//   Mode      in   2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 ROTR
//   ValueIn   in   operand, sampled with Start
//   ShAmt     in   shift amount, sampled with Start
//   Busy      out  high in SHIFT and DONE (decoded from the state register)
//   Done      out  one-cycle pulse, ValueOut is new
//   ValueOut  out  result register, held until the next Done
//
// Build option:
//   ITERATIVE_SHIFTER_ROTATE_EN  defined: Mode 2'b11 rotates right.
//                                undefined: Mode 2'b11 behaves as SRL.
// -----------------------------------------------------------------------------
module iterative_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Start,
  input  logic [1:0]               Mode,
  input  logic [WIDTH-1:0]         ValueIn,
  input  logic [$clog2(WIDTH)-1:0] ShAmt,
  output logic                     Busy,
  output logic                     Done,
  output logic [WIDTH-1:0]         ValueOut
);

  localparam int AW = $clog2(WIDTH);
  // One extra bit so that STEP == WIDTH is representable.
  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  localparam logic [1:0] MODE_SLL  = 2'b00;
  localparam logic [1:0] MODE_SRL  = 2'b01;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] acc_r;
  logic [AW-1:0]    rem_r;
  logic [1:0]       mode_r;
  logic             sign_r;
  logic             done_r;
  logic [WIDTH-1:0] value_out_r;

  logic [AW-1:0]    n_s;
  logic [AW-1:0]    rem_nxt_s;
  logic [WIDTH-1:0] fill_s;
  logic [WIDTH-1:0] shifted_s;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
  localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);
  logic [AW:0]      lamt_s;
`endif

  assign Busy     = (state_r != ST_IDLE);
  assign Done     = done_r;
  assign ValueOut = value_out_r;

  // Sub-shift amount for this cycle: min(rem, STEP).
  always_comb begin
    n_s = rem_r;
    if ({1'b0, rem_r} > STEP_W) begin
      n_s = STEP_W[AW-1:0];
    end else begin
      n_s = rem_r;
    end
    rem_nxt_s = rem_r - n_s;
  end

  // One sub-shift of the accumulator according to the latched mode.
  always_comb begin
    shifted_s = acc_r;
    // SRA fill uses the sign captured at accept, not the running accumulator MSB.
    if (sign_r) begin
      fill_s = ~({WIDTH{1'b1}} >> n_s);
    end else begin
      fill_s = {WIDTH{1'b0}};
    end
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    lamt_s = WIDTH_W - {1'b0, n_s};
`endif
    case (mode_r)
      MODE_SLL:  shifted_s = acc_r << n_s;
      MODE_SRL:  shifted_s = acc_r >> n_s;
      MODE_SRA:  shifted_s = (acc_r >> n_s) | fill_s;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      // n_s is never zero in SHIFT, so lamt_s stays below WIDTH.
      MODE_ROTR: shifted_s = (acc_r >> n_s) | (acc_r << lamt_s);
`else
      MODE_ROTR: shifted_s = acc_r >> n_s;
`endif
      default:   shifted_s = acc_r;
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          if (ShAmt != {AW{1'b0}}) begin
            state_nxt_s = ST_SHIFT;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rem_nxt_s == {AW{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= {WIDTH{1'b0}};
      rem_r       <= {AW{1'b0}};
      mode_r      <= 2'b00;
      sign_r      <= 1'b0;
      done_r      <= 1'b0;
      value_out_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            acc_r  <= ValueIn;
            rem_r  <= ShAmt;
            mode_r <= Mode;
            sign_r <= ValueIn[WIDTH-1];
            if (ShAmt == {AW{1'b0}}) begin
              value_out_r <= ValueIn;
              done_r      <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          acc_r <= shifted_s;
          rem_r <= rem_nxt_s;
          if (rem_nxt_s == {AW{1'b0}}) begin
            value_out_r <= shifted_s;
            done_r      <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// -----------------------------------------------------------------------------
// tb_iterative_shifter
//
// Directed bench for iterative_shifter. Three instances (STEP = 1, 4, 32,
// WIDTH = 32) share the request inputs; directed cases look at the STEP=4
// instance, the mode/amount sweep checks all three against a reference model.
// -----------------------------------------------------------------------------
module tb_iterative_shifter;

  localparam int W = 32;

  logic          Clk;
  logic          Reset_n;
  logic          Start;
  logic [1:0]    Mode;
  logic [W-1:0]  ValueIn;
  logic [4:0]    ShAmt;
  logic          busy_w [3];
  logic          done_w [3];
  logic [W-1:0]  vo_w   [3];

  int n_vec;
  int n_err;

  // Per-instance results of the last run_op.
  int           lat_r   [3];
  int           cnt_r   [3];
  int           bcnt_r  [3];
  logic [W-1:0] val_r   [3];
  int           step_tab [3];

  iterative_shifter #(.WIDTH(W), .STEP(1)) u_dut_s1 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode),
    .ValueIn(ValueIn), .ShAmt(ShAmt),
    .Busy(busy_w[0]), .Done(done_w[0]), .ValueOut(vo_w[0]));

  iterative_shifter #(.WIDTH(W), .STEP(4)) u_dut_s4 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode),
    .ValueIn(ValueIn), .ShAmt(ShAmt),
    .Busy(busy_w[1]), .Done(done_w[1]), .ValueOut(vo_w[1]));

  iterative_shifter #(.WIDTH(W), .STEP(32)) u_dut_s32 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode),
    .ValueIn(ValueIn), .ShAmt(ShAmt),
    .Busy(busy_w[2]), .Done(done_w[2]), .ValueOut(vo_w[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input logic [W-1:0] v,
                                             input logic [4:0] a);
    logic [2*W-1:0] d;
    d = {v, v} >> a;
    case (m)
      2'b00:   ref_shift = v << a;
      2'b01:   ref_shift = v >> a;
      2'b10:   ref_shift = W'($signed(v) >>> a);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      2'b11:   ref_shift = d[W-1:0];
`else
      2'b11:   ref_shift = v >> a;
`endif
      default: ref_shift = 32'h0;
    endcase
  endfunction

  // Issue one request (held for the accept edge only) and watch all instances
  // for 40 cycles. Inputs are scrambled after accept.
  task automatic run_op(input logic [1:0] m, input logic [W-1:0] v, input logic [4:0] a);
    Mode = m; ValueIn = v; ShAmt = a; Start = 1'b1;
    step();
    Start = 1'b0; Mode = ~m; ValueIn = ~v; ShAmt = ~a;
    for (int i = 0; i < 3; i++) begin
      lat_r[i] = -1; cnt_r[i] = 0; bcnt_r[i] = 0; val_r[i] = 32'h0;
    end
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) bcnt_r[i]++;
        if (done_w[i]) begin
          cnt_r[i]++;
          if (lat_r[i] < 0) begin
            lat_r[i] = c;
            val_r[i] = vo_w[i];
          end
        end
      end
      step();
    end
  endtask

  initial begin
    int dcnt;
    logic [W-1:0] v;
    logic [W-1:0] e;
    int exp_lat;
    n_vec = 0; n_err = 0;
    step_tab[0] = 1; step_tab[1] = 4; step_tab[2] = 32;
    Reset_n = 1'b0; Start = 1'b0; Mode = 2'b00; ValueIn = 32'h0; ShAmt = 5'd0;
    step(); step();
    check("rst_busy", 64'(busy_w[1]), 64'd0);
    check("rst_done", 64'(done_w[1]), 64'd0);
    check("rst_vout", 64'(vo_w[1]), 64'd0);
    Reset_n = 1'b1;
    step();

    // SLL 1 by 2
    run_op(2'b00, 32'h0000_0001, 5'd2);
    check("sll_val", 64'(val_r[1]), 64'h0000_0004);
    check("sll_lat", 64'(lat_r[1]), 64'd1);
    check("sll_busy", 64'(bcnt_r[1]), 64'd2);
    check("sll_cnt", 64'(cnt_r[1]), 64'd1);

    // SRA / SRL of 0x8000_00F0 by 9
    run_op(2'b10, 32'h8000_00F0, 5'd9);
    check("sra_val", 64'(val_r[1]), 64'hFFC0_0000);
    check("sra_lat", 64'(lat_r[1]), 64'd3);
    check("sra_hold", 64'(vo_w[1]), 64'hFFC0_0000);
    run_op(2'b01, 32'h8000_00F0, 5'd9);
    check("srl_val", 64'(val_r[1]), 64'h0040_0000);

    // ROTR 0xAB by 4
    run_op(2'b11, 32'h0000_00AB, 5'd4);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    check("rotr_val", 64'(val_r[1]), 64'hB000_000A);
`else
    check("rotr_val", 64'(val_r[1]), 64'h0000_000A);
`endif
    check("rotr_lat", 64'(lat_r[1]), 64'd1);

    // ShAmt = 0 with Start held high
    Mode = 2'b00; ValueIn = 32'h1234_5678; ShAmt = 5'd0; Start = 1'b1;
    step();
    check("zero_done0", 64'(done_w[1]), 64'd1);
    check("zero_val", 64'(vo_w[1]), 64'h1234_5678);
    check("zero_busy0", 64'(busy_w[1]), 64'd1);
    step();
    check("zero_done1", 64'(done_w[1]), 64'd0);
    check("zero_busy1", 64'(busy_w[1]), 64'd0);
    step();
    check("zero_done2", 64'(done_w[1]), 64'd1);
    Start = 1'b0;
    step(); step();

    // Abort SLL 0xFFFF_FFFF by 31 after edge 3
    Mode = 2'b00; ValueIn = 32'hFFFF_FFFF; ShAmt = 5'd31; Start = 1'b1;
    step();
    Start = 1'b0;
    step(); step(); step();
    check("abort_busy_pre", 64'(busy_w[1]), 64'd1);
    check("abort_vout_pre", 64'(vo_w[1]), 64'h1234_5678);
    Reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_w[1]), 64'd0);
    check("abort_done", 64'(done_w[1]), 64'd0);
    check("abort_vout", 64'(vo_w[1]), 64'd0);
    #2;
    Reset_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_w[1]) dcnt++;
      step();
    end
    check("abort_nodone", 64'(dcnt), 64'd0);
    run_op(2'b00, 32'h0000_0003, 5'd1);
    check("post_val", 64'(val_r[1]), 64'h0000_0006);
    check("post_lat", 64'(lat_r[1]), 64'd1);

    // Sweep every mode and amount at STEP = 1, 4, 32
    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < 32; a++) begin
        v = $urandom;
        e = ref_shift(2'(m), v, 5'(a));
        run_op(2'(m), v, 5'(a));
        for (int i = 0; i < 3; i++) begin
          exp_lat = (a + step_tab[i] - 1) / step_tab[i];
          check($sformatf("sw_val s%0d m%0d a%0d", step_tab[i], m, a), 64'(val_r[i]), 64'(e));
          check($sformatf("sw_lat s%0d m%0d a%0d", step_tab[i], m, a), 64'(lat_r[i]), 64'(exp_lat));
          check($sformatf("sw_cnt s%0d m%0d a%0d", step_tab[i], m, a), 64'(cnt_r[i]), 64'd1);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
